// File: rtl/io_pkg.sv
// io_pkg: shared constants and types for the board IO conditioning blocks.
//   BTN_N_DEFAULT     number of ULX3S push buttons
//   TICK_DIV_DEFAULT  clk cycles per debounce sampling tick
//   DB_TICKS_DEFAULT  ticks a new level must hold before it is accepted
//   ULX3S_BTN_INV     per-button pad inversion (bit 0 = PWR, active-low)
//   db_state_e        per-channel debounce state
package io_pkg;

    localparam int         BTN_N_DEFAULT    = 7;
    localparam int         TICK_DIV_DEFAULT = 1024;
    localparam int         DB_TICKS_DEFAULT = 16;
    localparam logic [6:0] ULX3S_BTN_INV    = 7'b0000001;

    typedef enum logic {
        DB_STABLE = 1'b0,
        DB_COUNT  = 1'b1
    } db_state_e;

endpackage

// File: rtl/btn_debounce_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every DIV cycles.
// The counter runs 0..DIV-1 and tick is high while it sits at DIV-1.
//   clk     system clock
//   resetn  asynchronous active-low reset
//   tick    one-cycle pulse, period DIV (constantly high when DIV == 1)
module tick_gen #(
    parameter int DIV = 1024
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          tick_r;

    // Wrap the prescaler after DIV-1
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Prescaler register; tick is registered from the next count so it aligns with cnt_r == DIV-1
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r  <= CNT_ZERO;
            tick_r <= (CNT_LAST == CNT_ZERO);
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == CNT_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: conditions raw push-button pads for the SoC.
// Each channel is synchronized, debounced against a shared slow tick, and
// reported as a stable level plus one-cycle rise/fall pulses. Rising edges
// set sticky event flags that the SoC clears by writing ones to ev_clr.
//   clk         system clock
//   resetn      asynchronous active-low reset
//   btn_raw     raw pad inputs (asynchronous)
//   btn_level   debounced level, 1 = pressed
//   btn_rise    one-cycle pulse on 0->1 of btn_level
//   btn_fall    one-cycle pulse on 1->0 of btn_level
//   ev_pending  sticky press flags
//   ev_clr      write-one-to-clear for ev_pending
//   irq         OR of ev_pending
module btn_debounce
    import io_pkg::*;
#(
    parameter int               N_BTN       = BTN_N_DEFAULT,
    parameter int               SYNC_STAGES = 2,
    parameter int               TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int               DB_TICKS    = DB_TICKS_DEFAULT,
    parameter logic [N_BTN-1:0] INV_MASK    = N_BTN'(ULX3S_BTN_INV)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] ev_pending,
    input  logic [N_BTN-1:0] ev_clr,
    output logic             irq
);

    localparam int            CW       = $clog2(DB_TICKS);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic [N_BTN-1:0] sync_r [SYNC_STAGES];
    logic [N_BTN-1:0] samp_s;
    logic             tick_s;
    logic [N_BTN-1:0] pend_r;
    logic [N_BTN-1:0] pend_nxt_s;
    logic             irq_r;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick_s)
    );

    // Synchronizer chain; resets to the pad's inactive level so no false press appears
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= INV_MASK;
            end
        end else begin
            sync_r[0] <= btn_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign samp_s = sync_r[SYNC_STAGES-1] ^ INV_MASK;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        db_state_e     state_r;
        db_state_e     state_nxt_s;
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_nxt_s;
        logic          level_r;
        logic          level_nxt_s;
        logic          rise_r;
        logic          rise_nxt_s;
        logic          fall_r;
        logic          fall_nxt_s;

        // Count ticks while the sample disagrees with the level; accept it on the DB_TICKS-th tick
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            level_nxt_s = level_r;
            rise_nxt_s  = 1'b0;
            fall_nxt_s  = 1'b0;
            case (state_r)
                DB_STABLE: begin
                    if (samp_s[i] != level_r) begin
                        state_nxt_s = DB_COUNT;
                        // a tick coinciding with the first disagreeing sample already counts
                        if (tick_s) begin
                            cnt_nxt_s = CNT_ONE;
                        end else begin
                            cnt_nxt_s = CNT_ZERO;
                        end
                    end else begin
                        state_nxt_s = DB_STABLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                DB_COUNT: begin
                    if (samp_s[i] == level_r) begin
                        state_nxt_s = DB_STABLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (tick_s) begin
                        if (cnt_r == CNT_LAST) begin
                            state_nxt_s = DB_STABLE;
                            cnt_nxt_s   = CNT_ZERO;
                            level_nxt_s = samp_s[i];
                            rise_nxt_s  = samp_s[i];
                            fall_nxt_s  = ~samp_s[i];
                        end else begin
                            cnt_nxt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = DB_STABLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end

        // Channel state, counter, level and edge pulse registers
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_r <= DB_STABLE;
                cnt_r   <= CNT_ZERO;
                level_r <= 1'b0;
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
                level_r <= level_nxt_s;
                rise_r  <= rise_nxt_s;
                fall_r  <= fall_nxt_s;
            end
        end

        assign btn_level[i] = level_r;
        assign btn_rise[i]  = rise_r;
        assign btn_fall[i]  = fall_r;
    end

    // Set from the registered rise pulse so a clear in the pulse cycle loses to the set
    always_comb begin
        pend_nxt_s = btn_rise | (pend_r & ~ev_clr);
    end

    // Event flags; irq uses the next-state so it tracks ev_pending without extra delay
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_r <= {N_BTN{1'b0}};
            irq_r  <= 1'b0;
        end else begin
            pend_r <= pend_nxt_s;
            irq_r  <= |pend_nxt_s;
        end
    end

    assign ev_pending = pend_r;
    assign irq        = irq_r;

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

    localparam int         N   = 2;
    localparam int         SS  = 2;
    localparam int         TD  = 4;
    localparam int         DB  = 3;
    localparam logic [1:0] INV = 2'b01;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] btn_raw = 2'b01;
    logic [1:0] ev_clr  = 2'b00;
    logic [1:0] btn_level, btn_rise, btn_fall, ev_pending;
    logic       irq;

    int total = 0;
    int bad   = 0;

    // Reference model: pad history, tick phase and ticks seen while the sample disagrees
    logic [1:0] m_s1, m_s2, m_level, m_rise, m_fall, m_pend;
    logic       m_irq;
    int         m_cnt [2];
    int         k;

    logic [8:0] dut_o;
    logic [8:0] mod_o;
    assign dut_o = {btn_level, btn_rise, btn_fall, ev_pending, irq};
    assign mod_o = {m_level, m_rise, m_fall, m_pend, m_irq};

    always #5 clk = ~clk;

    btn_debounce #(
        .N_BTN       (N),
        .SYNC_STAGES (SS),
        .TICK_DIV    (TD),
        .DB_TICKS    (DB),
        .INV_MASK    (INV)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .ev_pending (ev_pending),
        .ev_clr     (ev_clr),
        .irq        (irq)
    );

    task automatic model_reset();
        m_s1 = INV; m_s2 = INV;
        m_level = 2'b00; m_rise = 2'b00; m_fall = 2'b00; m_pend = 2'b00; m_irq = 1'b0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        k = 0;
    endtask

    // One clock: advance the model by the spec rules, then settle 1 time unit past the edge
    task automatic cycle();
        logic       tick;
        logic       s;
        logic [1:0] nr, nf;
        @(posedge clk);
        tick = ((k % TD) == (TD - 1));
        nr = 2'b00; nf = 2'b00;
        for (int i = 0; i < N; i++) begin
            s = m_s2[i] ^ INV[i];
            if (s == m_level[i]) begin
                m_cnt[i] = 0;
            end else if (tick) begin
                if (m_cnt[i] == DB - 1) begin
                    m_level[i] = s;
                    m_cnt[i]   = 0;
                    nr[i] = s;
                    nf[i] = ~s;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        m_pend = m_rise | (m_pend & ~ev_clr);
        m_irq  = |m_pend;
        m_rise = nr;
        m_fall = nf;
        m_s2 = m_s1;
        m_s1 = btn_raw;
        k = k + 1;
        #1;
    endtask

    task automatic apply_reset(input logic [1:0] raw);
        btn_raw = raw;
        ev_clr  = 2'b00;
        resetn  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        btn_raw = 2'b01; ev_clr = 2'b00; resetn = 1'b0;
        #2;
        total++;
        if (dut_o !== 9'b0) begin bad++; $display("FAIL reset_async: got %b want %b", dut_o, 9'b0); end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut_o !== 9'b0) begin bad++; $display("FAIL reset_held: got %b want %b", dut_o, 9'b0); end
        resetn = 1'b1;
        model_reset();
        repeat (6) begin
            cycle();
            total++;
            if (dut_o !== mod_o) begin bad++; $display("FAIL reset_idle: got %b want %b", dut_o, mod_o); end
        end
    endtask

    task automatic test_clean_press();
        int first = -1;
        int rises = 0;
        btn_raw = 2'b11;
        for (int c = 1; c <= 30; c++) begin
            cycle();
            total++;
            if (dut_o !== mod_o) begin bad++; $display("FAIL press_cycle%0d: got %b want %b", c, dut_o, mod_o); end
            if (btn_level[1] && first < 0) first = c;
            if (btn_rise[1]) rises++;
        end
        total++;
        if (first < 11 || first > 14) begin bad++; $display("FAIL press_latency: got %0d want 11..14", first); end
        total++;
        if (rises != 1) begin bad++; $display("FAIL press_rise_width: got %0d want 1", rises); end
        total++;
        if (ev_pending !== 2'b10 || irq !== 1'b1) begin
            bad++; $display("FAIL press_event: got pend=%b irq=%b want pend=10 irq=1", ev_pending, irq);
        end
    endtask

    task automatic test_clear();
        ev_clr = 2'b10;
        cycle();
        ev_clr = 2'b00;
        total++;
        if (ev_pending !== 2'b00 || irq !== 1'b0) begin
            bad++; $display("FAIL clear: got pend=%b irq=%b want pend=00 irq=0", ev_pending, irq);
        end
    endtask

    task automatic test_release();
        int first = -1;
        int falls = 0;
        btn_raw = 2'b01;
        for (int c = 1; c <= 30; c++) begin
            cycle();
            total++;
            if (dut_o !== mod_o) begin bad++; $display("FAIL release_cycle%0d: got %b want %b", c, dut_o, mod_o); end
            if (!btn_level[1] && first < 0) first = c;
            if (btn_fall[1]) falls++;
        end
        total++;
        if (first < 11 || first > 14) begin bad++; $display("FAIL release_latency: got %0d want 11..14", first); end
        total++;
        if (falls != 1) begin bad++; $display("FAIL release_fall_count: got %0d want 1", falls); end
        total++;
        if (ev_pending !== 2'b00) begin bad++; $display("FAIL release_pend: got %b want 00", ev_pending); end
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 26; c++) begin
            btn_raw = (c < 6) ? 2'b11 : 2'b01;
            cycle();
            total++;
            if (btn_level !== 2'b00 || btn_rise !== 2'b00 || ev_pending !== 2'b00 || dut_o !== mod_o) begin
                bad++; $display("FAIL glitch_cycle%0d: got %b want %b", c, dut_o, mod_o);
            end
        end
        total++;
        if (dut.g_ch[1].cnt_r !== 2'b00) begin bad++; $display("FAIL glitch_cnt: got %0d want 0", dut.g_ch[1].cnt_r); end
    endtask

    task automatic test_clear_with_rise();
        int hit = 0;
        btn_raw = 2'b11;
        for (int c = 0; c < 30; c++) begin
            cycle();
            total++;
            if (dut_o !== mod_o) begin bad++; $display("FAIL clr_rise_cycle%0d: got %b want %b", c, dut_o, mod_o); end
            if (ev_clr != 2'b00) begin
                total++;
                if (ev_pending[1] !== 1'b1) begin bad++; $display("FAIL clr_rise_setwins: got %b want 1", ev_pending[1]); end
                ev_clr = 2'b00;
            end
            if (m_rise[1]) begin ev_clr = 2'b10; hit++; end
        end
        total++;
        if (hit != 1) begin bad++; $display("FAIL clr_rise_hit: got %0d want 1", hit); end
    endtask

    task automatic test_inverted();
        int rises = 0;
        apply_reset(2'b01);
        repeat (20) cycle();
        total++;
        if (btn_level[0] !== 1'b0) begin bad++; $display("FAIL inv_idle: got %b want 0", btn_level[0]); end
        btn_raw = 2'b00;
        for (int c = 0; c < 20; c++) begin
            cycle();
            total++;
            if (dut_o !== mod_o) begin bad++; $display("FAIL inv_cycle%0d: got %b want %b", c, dut_o, mod_o); end
            if (btn_rise[0]) rises++;
        end
        total++;
        if (rises != 1 || ev_pending[0] !== 1'b1) begin
            bad++; $display("FAIL inv_press: got rises=%0d pend=%b want rises=1 pend0=1", rises, ev_pending);
        end
    endtask

    task automatic test_reset_midcount();
        int rises = 0;
        int guard = 0;
        apply_reset(2'b01);
        btn_raw = 2'b11;
        while (m_cnt[1] != 1 && guard < 20) begin cycle(); guard++; end
        total++;
        if (guard >= 20) begin bad++; $display("FAIL midcount_reach: got guard=%0d want <20", guard); end
        resetn = 1'b0;
        #1;
        total++;
        if (dut_o !== 9'b0) begin bad++; $display("FAIL midcount_async: got %b want %b", dut_o, 9'b0); end
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        for (int c = 0; c < 30; c++) begin
            cycle();
            total++;
            if (dut_o !== mod_o) begin bad++; $display("FAIL midcount_cycle%0d: got %b want %b", c, dut_o, mod_o); end
            if (btn_rise[1]) rises++;
        end
        total++;
        if (rises != 1 || ev_pending !== 2'b10) begin
            bad++; $display("FAIL midcount_rise: got rises=%0d pend=%b want 1/10", rises, ev_pending);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        apply_reset(2'($urandom_range(0, 3)));
        for (int c = 0; c < 1200; c++) begin
            if (hold == 0) begin
                btn_raw = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 20);
            end
            hold--;
            ev_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cycle();
            total++;
            if (dut_o !== mod_o) begin bad++; $display("FAIL random_cycle%0d: got %b want %b", c, dut_o, mod_o); end
        end
        ev_clr = 2'b00;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_clear();
        test_release();
        test_glitch();
        test_clear_with_rise();
        test_inverted();
        test_reset_midcount();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
